// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (I,
// read-only) and load/store (D, read/write). D has priority, but I is
// guaranteed a grant after at most D_STREAK_MAX consecutive D grants.
// Each access times out after TIMEOUT bus cycles without m_ready.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int D_STREAK_MAX = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              clrn,
    // instruction fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    output logic              i_stall,
    // load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    // memory port
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    // status
    output logic              err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, BUS_I, BUS_D} state_t;

    localparam logic [3:0] SMAX     = 4'(D_STREAK_MAX);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [3:0] streak;
    logic [7:0] tcnt;

    logic i_req_m, d_req_m, d_win, i_win, tmo_hit;

    // Arbitration terms; a requester in its ack cycle is masked so its
    // still-held request is not granted a second time.
    always_comb begin
        i_req_m = i_req & ~i_ack;
        d_req_m = d_req & ~d_ack;
        d_win   = d_req_m & (~i_req_m | (streak < SMAX));
        i_win   = ~d_win & i_req_m;
        tmo_hit = (tcnt == TMO_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: grant from IDLE, return to IDLE on ready or timeout.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (d_win)      state_nxt = BUS_D;
                else if (i_win) state_nxt = BUS_I;
            end
            BUS_I, BUS_D: begin
                if (m_ready || tmo_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-side registers, acks, read data capture and the two counters.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            err     <= 1'b0;
            streak  <= '0;
            tcnt    <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (d_win) begin
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        tcnt    <= '0;
                        if (!i_req_m)          streak <= '0;
                        else if (streak != SMAX) streak <= streak + 4'd1;
                    end else if (i_win) begin
                        m_req  <= 1'b1;
                        m_we   <= 1'b0;
                        m_addr <= i_addr;
                        tcnt   <= '0;
                        streak <= '0;
                    end
                end
                BUS_I, BUS_D: begin
                    if (m_ready) begin
                        m_req <= 1'b0;
                        if (state == BUS_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= m_rdata;
                        end else begin
                            d_ack <= 1'b1;
                            if (!m_we) d_rdata <= m_rdata;
                        end
                    end else begin
                        tcnt <= tcnt + 8'd1;
                        if (tmo_hit) begin
                            // abort: ack with err, read data left untouched
                            m_req <= 1'b0;
                            err   <= 1'b1;
                            if (state == BUS_I) i_ack <= 1'b1;
                            else                d_ack <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Combinational status outputs.
    always_comb begin
        busy    = (state != IDLE);
        i_stall = i_req & ~i_ack;
        d_stall = d_req & ~d_ack;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized requesters/memory against a transaction-level
// model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SMAX = 4;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ack, i_stall;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ack, d_stall;
    logic          m_req, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;
    logic          m_ready = 1'b0;
    logic          err, busy;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_STREAK_MAX(SMAX), .TIMEOUT(TMO)) dut (
        .clk(clk), .clrn(clrn),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    bit mem_rand = 1'b0;
    bit req_rand = 1'b0;
    int rdy_pct  = 50;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_assert++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // owner: 0 = nobody on the bus, 1 = fetch access, 2 = load/store access
    typedef struct packed {
        logic [1:0]    owner;
        logic          mreq;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [7:0]    waited;
        logic [3:0]    streak;
        logic          iack;
        logic          dack;
        logic          err;
        logic [DW-1:0] irdata;
        logic [DW-1:0] drdata;
    } mdl_t;

    mdl_t mdl;

    function automatic mdl_t mdl_next(input mdl_t s);
        mdl_t n;
        logic im, dm;
        n = s;
        n.iack = 1'b0;
        n.dack = 1'b0;
        n.err  = 1'b0;
        if (s.owner == 2'd0) begin
            im = i_req & ~s.iack;
            dm = d_req & ~s.dack;
            if (dm && (!im || int'(s.streak) < SMAX)) begin
                n.owner = 2'd2; n.mreq = 1'b1; n.we = d_we;
                n.addr = d_addr; n.wdata = d_wdata; n.waited = '0;
                if (!im) n.streak = '0;
                else if (int'(s.streak) < SMAX) n.streak = s.streak + 4'd1;
            end else if (im) begin
                n.owner = 2'd1; n.mreq = 1'b1; n.we = 1'b0;
                n.addr = i_addr; n.waited = '0; n.streak = '0;
            end
        end else if (m_ready) begin
            if (s.owner == 2'd1) begin n.iack = 1'b1; n.irdata = m_rdata; end
            else begin n.dack = 1'b1; if (!s.we) n.drdata = m_rdata; end
            n.owner = 2'd0; n.mreq = 1'b0;
        end else begin
            n.waited = s.waited + 8'd1;
            if (int'(n.waited) == TMO) begin
                if (s.owner == 2'd1) n.iack = 1'b1; else n.dack = 1'b1;
                n.err = 1'b1; n.owner = 2'd0; n.mreq = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge clrn) begin
        if (!clrn) mdl <= '0;
        else       mdl <= mdl_next(mdl);
    end

    // ---------------- per-cycle compare against the model ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en && clrn) begin
                check("i_ack", i_ack, mdl.iack);
                check("d_ack", d_ack, mdl.dack);
                check("err", err, mdl.err);
                check("busy", busy, mdl.owner != 2'd0);
                check("m_req", m_req, mdl.mreq);
                check("i_rdata", i_rdata, mdl.irdata);
                check("d_rdata", d_rdata, mdl.drdata);
                check("i_stall", i_stall, i_req & ~mdl.iack);
                check("d_stall", d_stall, d_req & ~mdl.dack);
                check("ack_excl", i_ack & d_ack, 1'b0);
                if (mdl.mreq) begin
                    check("m_we", m_we, mdl.we);
                    check("m_addr", m_addr, mdl.addr);
                    if (mdl.we) check("m_wdata", m_wdata, mdl.wdata);
                end
            end
        end
    end

    // One clock step; inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
        if (mem_rand) begin
            m_ready = ($urandom_range(0, 99) < rdy_pct);
            m_rdata = $urandom;
        end
        if (req_rand) begin
            if (i_ack) begin
                if ($urandom_range(0, 1) == 0) i_req = 1'b0;
                else i_addr = $urandom;
            end else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            if (d_ack) begin
                if ($urandom_range(0, 1) == 0) d_req = 1'b0;
                else begin d_addr = $urandom; d_we = 1'($urandom); d_wdata = $urandom; end
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_addr = $urandom; d_we = 1'($urandom); d_wdata = $urandom;
            end
        end
    endtask

    int order[12];
    int n_acc;
    int cnt;
    bit done;

    initial begin
        // ---- reset state ----
        repeat (2) @(posedge clk);
        #2;
        check("rst_m_req", m_req, 1'b0);
        check("rst_i_ack", i_ack, 1'b0);
        check("rst_d_ack", d_ack, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_m_addr", m_addr, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        clrn = 1'b1;
        chk_en = 1'b1;
        step();

        // ---- single load ----
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        step();
        check("ld_m_req", m_req, 1'b1);
        check("ld_m_addr", m_addr, 32'h10);
        check("ld_m_we", m_we, 1'b0);
        check("ld_stall", d_stall, 1'b1);
        step();
        check("ld_stall2", d_stall, 1'b1);
        m_ready = 1'b1; m_rdata = 32'h30000033;
        step();
        check("ld_ack", d_ack, 1'b1);
        check("ld_rdata", d_rdata, 32'h30000033);
        check("ld_stall_ack", d_stall, 1'b0);
        d_req = 1'b0; m_ready = 1'b0;
        step();
        check("ld_ack_once", d_ack, 1'b0);
        check("ld_idle", busy, 1'b0);

        // ---- store then fetch ----
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hA00000AA;
        i_req = 1'b1; i_addr = 32'h190;
        step();
        check("st_m_we", m_we, 1'b1);
        check("st_m_addr", m_addr, 32'h8);
        check("st_m_wdata", m_wdata, 32'hA00000AA);
        m_ready = 1'b1; m_rdata = 32'hDEADBEEF;
        step();
        check("st_ack", d_ack, 1'b1);
        check("st_rdata_keep", d_rdata, 32'h30000033);
        check("st_no_iack", i_ack, 1'b0);
        d_req = 1'b0; m_ready = 1'b0;
        step();
        check("if_m_req", m_req, 1'b1);
        check("if_m_addr", m_addr, 32'h190);
        check("if_m_we", m_we, 1'b0);
        m_ready = 1'b1; m_rdata = 32'h11112222;
        step();
        check("if_ack", i_ack, 1'b1);
        check("if_rdata", i_rdata, 32'h11112222);
        i_req = 1'b0; m_ready = 1'b0;
        step();

        // ---- starvation bound: both held, memory answers in one cycle ----
        m_ready = 1'b1; m_rdata = 32'h55AA55AA;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        i_req = 1'b1; i_addr = 32'h200;
        n_acc = 0;
        for (int t = 0; t < 80 && n_acc < 12; t++) begin
            step();
            if (d_ack) begin order[n_acc] = 1; n_acc++; d_addr = d_addr + 32'h4; end
            if (i_ack) begin order[n_acc] = 0; n_acc++; i_addr = i_addr + 32'h4; end
        end
        d_req = 1'b0; i_req = 1'b0;
        check("starve_count", n_acc, 12);
        for (int k = 0; k < 12; k++)
            check($sformatf("starve_order%0d", k), order[k], (k % 2 == 0) ? 1 : 0);
        m_ready = 1'b0;
        step();
        step();

        // ---- timeout on a fetch ----
        i_req = 1'b1; i_addr = 32'h40;
        cnt = 0; done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            step();
            if (m_req) cnt++;
            if (i_ack) begin
                done = 1'b1;
                check("tmo_err", err, 1'b1);
                check("tmo_rdata_keep", i_rdata, 32'h55AA55AA);
                check("tmo_m_req_drop", m_req, 1'b0);
                i_req = 1'b0;
            end
        end
        check("tmo_acked", done, 1'b1);
        check("tmo_cycles", cnt, TMO);
        step();
        check("tmo_err_pulse", err, 1'b0);
        i_req = 1'b1; i_addr = 32'h44; m_ready = 1'b1; m_rdata = 32'h0BADF00D;
        done = 1'b0;
        for (int t = 0; t < 10 && !done; t++) begin
            step();
            if (i_ack) begin
                done = 1'b1;
                check("after_tmo_err", err, 1'b0);
                check("after_tmo_rdata", i_rdata, 32'h0BADF00D);
                i_req = 1'b0;
            end
        end
        check("after_tmo_acked", done, 1'b1);

        // ---- spurious ready while idle ----
        m_ready = 1'b1;
        step();
        for (int t = 0; t < 5; t++) begin
            step();
            check("spur_busy", busy, 1'b0);
            check("spur_ack", i_ack | d_ack, 1'b0);
            check("spur_m_req", m_req, 1'b0);
        end
        m_ready = 1'b0;

        // ---- reset in the middle of a load/store access ----
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
        step();
        check("rmid_m_req", m_req, 1'b1);
        check("rmid_busy", busy, 1'b1);
        clrn = 1'b0;
        #1;
        check("rmid_m_req0", m_req, 1'b0);
        check("rmid_d_ack0", d_ack, 1'b0);
        check("rmid_busy0", busy, 1'b0);
        d_req = 1'b0;
        step();
        step();
        clrn = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step();
            check("rpost_m_req", m_req, 1'b0);
            check("rpost_ack", i_ack | d_ack, 1'b0);
            check("rpost_busy", busy, 1'b0);
        end

        // ---- randomized traffic checked by the model ----
        mem_rand = 1'b1;
        req_rand = 1'b1;
        for (int t = 0; t < 4000; t++) begin
            rdy_pct = ((t / 500) % 2 == 1) ? 4 : 60;
            step();
        end
        req_rand = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (40) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: instruction fetch (I, read-only) and the load/store stage (D, read/write).
- Sits between the IF / MEM pipeline stages and the memory.
- Serialises accesses through a request/ready handshake and gives D priority, with a bounded-starvation guarantee for I.
- Drives per-stage stall signals back to the pipeline and times out a memory that never responds.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- D_STREAK_MAX, 4, maximum consecutive D grants while I is waiting; range 1..15
- TIMEOUT, 15, BUS cycles without m_ready before abort; range 1..255

Ports:
- clk  in  1  system clock, rising edge
- clrn  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word; valid while i_ack=1
- i_ack  out  1  one-cycle completion pulse for I
- i_stall  out  1  i_req & ~i_ack (combinational)
- d_req  in  1  load/store request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse for D
- d_stall  out  1  d_req & ~d_ack (combinational)
- m_req  out  1  memory access request
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data; valid with m_ready
- m_ready  in  1  memory completion; sampled only in BUS states
- err  out  1  pulses with i_ack/d_ack when that access timed out
- busy  out  1  high in BUS_I or BUS_D

Behaviour:
- Reset: clk and clrn are the only clock and reset; reset is asynchronous and active-low. While clrn=0, the state is IDLE and every registered output is 0: m_req, m_we, m_addr, m_wdata, i_ack, d_ack, i_rdata, d_rdata, err, streak counter, timeout counter.
- Reset mid-access: m_req drops immediately, no ack is issued, and the access is lost. Requesters re-present after reset.
- States: IDLE, BUS_I, BUS_D. All m_* outputs are registered.
- IDLE arbitration, evaluated at each rising edge:
  - A requester whose ack is currently high is masked for this edge, so a held req is not re-granted.
  - D wins if d_req & (~i_req | streak < D_STREAK_MAX). Otherwise, if i_req is high, I wins. If neither requests, stay in IDLE.
- Grant: at the grant edge, latch the winner's addr (plus we/wdata for D; m_we=0 for I), set m_req=1, clear the timeout counter, and enter BUS_x.
- Streak counter:
  - On a D grant with i_req=1: increment, saturating at D_STREAK_MAX.
  - On a D grant with i_req=0: clear.
  - On an I grant: clear.
- BUS_x: m_req and the latched m_* values are held stable.
  - On an edge with m_ready=1: capture m_rdata into x_rdata (D only when m_we=0; d_rdata is unchanged on stores), pulse x_ack=1 for exactly one cycle, drop m_req, and return to IDLE.
  - On an edge with m_ready=0: increment the timeout counter. When it reaches TIMEOUT, drop m_req, pulse x_ack=1 and err=1, leave x_rdata unchanged, and return to IDLE.
- Latency: request sampled at edge N, m_ready sampled high at edge N+k (k≥1), ack high during cycle N+k..N+k+1. The next grant can occur at edge N+k+1. Minimum period per access is therefore 2 cycles.
- m_ready while in IDLE is ignored.
- Simultaneous requests: if D is acked while I is pending, I may be granted at the edge that ends the ack cycle, subject to the streak rule. D is masked at that edge, which gives alternation.
- Requesters must drop req or present a new request in the cycle after ack. Changing addr/wdata while waiting has no effect after the grant.
- i_ack and d_ack are never high in the same cycle.

Test Plan:
- Reset: clrn=0 mid BUS_D with m_req=1 -> m_req, d_ack and busy are 0 immediately; after release, state is IDLE, with no ack and no memory request until a req is presented.
- Single load: d_req=1, d_we=0, d_addr=0x10; memory asserts m_ready 2 cycles after m_req with m_rdata=0x30000033 -> m_addr=0x10, m_we=0; d_ack pulses once with d_rdata=0x30000033; d_stall is high until that cycle.
- Store then fetch: d_we=1, d_addr=0x8, d_wdata=0xA00000AA while i_req=1, i_addr=0x190 -> D is served first (m_we=1, m_wdata=0xA00000AA, d_rdata unchanged), then I is granted at the edge after d_ack with m_addr=0x190.
- Starvation bound: d_req and i_req held continuously, D re-presenting after each ack, memory k=1, D_STREAK_MAX=4 -> no I grant is starved beyond 4 consecutive D accesses. Verify the grant order over 12 accesses.
- Timeout: i_req=1 with m_ready held 0 -> m_req drops after exactly TIMEOUT=15 BUS cycles; i_ack=1 and err=1 for one cycle; i_rdata is unchanged; the next request is served normally with err=0.
- Spurious ready: m_ready=1 while IDLE with no requests -> no ack, no state change, and busy=0.
